dat_mem_arb: RTL and testbench

- Two-requester arbiter and sequencer for the 256 x 8 data memory: the single-ported array (combinational read, clocked write) is shared between the core load/store port (requester 0) and the block-copy/IO engine (requester 1).
- Round-robin arbitration, optional bus lock for atomic multi-byte sequences, registered read return.
- Sits between both requesters and the memory's dat_in/wr_en/addr/dat_out pins.

---
 rtl/dat_mem_arb.sv | 156 +++++++++++++++
 tb/tb_dat_mem_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dat_mem_arb.sv
// Round-robin arbiter with optional bus lock and registered read return for the shared 256x8 data memory.
// Define DAT_MEM_ARB_PERF_EN to add the saturating grant/wait performance counters.
module dat_mem_arb #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_LOCK = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_lock,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_lock,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_dat_in,
    input  logic [DW-1:0] mem_dat_out
`ifdef DAT_MEM_ARB_PERF_EN
    ,
    output logic [15:0]   gnt_cnt0,
    output logic [15:0]   gnt_cnt1,
    output logic [15:0]   wait_cnt1
`endif
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_R0   = 2'd1;
    localparam logic [1:0] OWN_R1   = 2'd2;
    localparam logic [8:0] LOCK_LIMIT = 9'(MAX_LOCK);

    logic [1:0] owner;
    logic       prio;
    logic [7:0] lock_cnt;

    logic       owner_active;
    logic       gnt0;
    logic       gnt1;
    logic       any_gnt;
    logic       sel_lock;
    logic       sel_we;
    logic [1:0] owner_next;
    logic       prio_next;
    logic [7:0] lock_cnt_next;

    // An owner that stops requesting loses the bus at once, so arbitration falls back to round-robin.
    always_comb begin
        owner_active = ((owner == OWN_R0) && r0_req) || ((owner == OWN_R1) && r1_req);
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (owner_active) begin
                gnt0 = (owner == OWN_R0);
                gnt1 = (owner == OWN_R1);
            end else if (r0_req && r1_req) begin
                gnt0 = !prio;
                gnt1 = prio;
            end else begin
                gnt0 = r0_req;
                gnt1 = r1_req;
            end
        end
    end

    assign any_gnt    = gnt0 | gnt1;
    assign r0_gnt     = gnt0;
    assign r1_gnt     = gnt1;
    assign mem_addr   = gnt1 ? r1_addr  : r0_addr;
    assign mem_dat_in = gnt1 ? r1_wdata : r0_wdata;
    assign sel_we     = gnt1 ? r1_we    : r0_we;
    assign sel_lock   = gnt1 ? r1_lock  : r0_lock;
    assign mem_wr_en  = any_gnt & sel_we;

    // The grant that would bring the locked run to MAX_LOCK is treated as unlocked, capping the run length.
    always_comb begin
        owner_next    = owner;
        prio_next     = prio;
        lock_cnt_next = lock_cnt;
        if (any_gnt) begin
            prio_next = gnt0;
            if (owner_active) begin
                if (sel_lock && (({1'b0, lock_cnt} + 9'd1) < LOCK_LIMIT)) begin
                    lock_cnt_next = lock_cnt + 8'd1;
                end else begin
                    owner_next    = OWN_NONE;
                    lock_cnt_next = 8'd0;
                end
            end else if (sel_lock && (LOCK_LIMIT > 9'd1)) begin
                owner_next    = gnt1 ? OWN_R1 : OWN_R0;
                lock_cnt_next = 8'd1;
            end else begin
                owner_next    = OWN_NONE;
                lock_cnt_next = 8'd0;
            end
        end else begin
            owner_next    = OWN_NONE;
            lock_cnt_next = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= OWN_NONE;
            prio      <= 1'b0;
            lock_cnt  <= 8'd0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            owner     <= owner_next;
            prio      <= prio_next;
            lock_cnt  <= lock_cnt_next;
            r0_rvalid <= gnt0 & ~r0_we;
            r1_rvalid <= gnt1 & ~r1_we;
            if (gnt0 && !r0_we) begin
                r0_rdata <= mem_dat_out;
            end
            if (gnt1 && !r1_we) begin
                r1_rdata <= mem_dat_out;
            end
        end
    end

`ifdef DAT_MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_cnt0  <= 16'd0;
            gnt_cnt1  <= 16'd0;
            wait_cnt1 <= 16'd0;
        end else begin
            if (gnt0 && (gnt_cnt0 != 16'hFFFF)) begin
                gnt_cnt0 <= gnt_cnt0 + 16'd1;
            end
            if (gnt1 && (gnt_cnt1 != 16'hFFFF)) begin
                gnt_cnt1 <= gnt_cnt1 + 16'd1;
            end
            if (r1_req && !gnt1 && (wait_cnt1 != 16'hFFFF)) begin
                wait_cnt1 <= wait_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dat_mem_arb.sv
// Self-checking bench for dat_mem_arb: directed vector table, max-lock run, and randomized traffic
// compared against a run-length ownership model with a shadow memory.
module tb_dat_mem_arb;

    localparam int ML = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       r0_req, r0_lock, r0_we;
    logic [7:0] r0_addr, r0_wdata;
    logic       r0_gnt, r0_rvalid;
    logic [7:0] r0_rdata;
    logic       r1_req, r1_lock, r1_we;
    logic [7:0] r1_addr, r1_wdata;
    logic       r1_gnt, r1_rvalid;
    logic [7:0] r1_rdata;
    logic [7:0] mem_addr, mem_dat_in, mem_dat_out;
    logic       mem_wr_en;
`ifdef DAT_MEM_ARB_PERF_EN
    logic [15:0] gnt_cnt0, gnt_cnt1, wait_cnt1;
`endif

    always #5 clk = ~clk;

    dat_mem_arb #(.AW(8), .DW(8), .MAX_LOCK(ML)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_lock(r0_lock), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_lock(r1_lock), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_dat_in(mem_dat_in), .mem_dat_out(mem_dat_out)
`ifdef DAT_MEM_ARB_PERF_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .wait_cnt1(wait_cnt1)
`endif
    );

    // Behavioural 256x8 memory: combinational read, write lands on the clock edge.
    logic [7:0] mem [256];
    assign mem_dat_out = mem[mem_addr];
    always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_dat_in;

    typedef struct packed {
        logic       rst;
        logic       q0, l0, w0;
        logic [7:0] a0, d0;
        logic       q1, l1, w1;
        logic [7:0] a1, d1;
        logic       eg0, eg1, ewr, erv0, erv1;
        logic [7:0] erd0, erd1;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: owner (-1 none), round-robin pointer, length of current locked run.
    int         m_owner, m_prio, m_run, last_g;
    logic       m_rv [2];
    logic [7:0] m_rd [2];
    logic [7:0] shadow [256];

    function automatic vec_t mk_vec(logic rst, logic q0, logic l0, logic w0, logic [7:0] a0, logic [7:0] d0,
                                    logic q1, logic l1, logic w1, logic [7:0] a1, logic [7:0] d1,
                                    logic eg0, logic eg1, logic ewr, logic erv0, logic erv1,
                                    logic [7:0] erd0, logic [7:0] erd1);
        vec_t v;
        v = '{rst, q0, l0, w0, a0, d0, q1, l1, w1, a1, d1, eg0, eg1, ewr, erv0, erv1, erd0, erd1};
        return v;
    endfunction

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        reset = v.rst;
        r0_req = v.q0; r0_lock = v.l0; r0_we = v.w0; r0_addr = v.a0; r0_wdata = v.d0;
        r1_req = v.q1; r1_lock = v.l1; r1_we = v.w1; r1_addr = v.a1; r1_wdata = v.d1;
    endtask

    function automatic int model_pick();
        logic [1:0] req;
        req = {r1_req, r0_req};
        if (reset) return -1;
        if (m_owner >= 0 && req[m_owner]) return m_owner;
        if (req == 2'b11) return m_prio;
        if (r0_req) return 0;
        if (r1_req) return 1;
        return -1;
    endfunction

    task automatic model_update(input int g);
        logic       we [2];
        logic       lk [2];
        logic [7:0] ad [2];
        logic [7:0] wd [2];
        we = '{r0_we, r1_we}; lk = '{r0_lock, r1_lock};
        ad = '{r0_addr, r1_addr}; wd = '{r0_wdata, r1_wdata};
        if (reset) begin
            m_owner = -1; m_prio = 0; m_run = 0;
            m_rv = '{1'b0, 1'b0}; m_rd = '{8'h00, 8'h00};
            return;
        end
        for (int i = 0; i < 2; i++) begin
            m_rv[i] = (g == i) && !we[i];
            if (m_rv[i]) m_rd[i] = shadow[ad[i]];
        end
        if (g >= 0 && we[g]) shadow[ad[g]] = wd[g];
        if (g >= 0) begin
            m_prio = 1 - g;
            m_run  = (g == m_owner) ? m_run + 1 : 1;
            if (lk[g] && m_run < ML) m_owner = g;
            else begin m_owner = -1; m_run = 0; end
        end else begin
            m_owner = -1; m_run = 0;
        end
    endtask

    // One clock of model-checked traffic: combinational outputs before the edge, registered after.
    task automatic run_cycle();
        int g;
        g = model_pick();
        last_g = g;
        #1;
        check_output("gnt0", r0_gnt, 16'(g == 0));
        check_output("gnt1", r1_gnt, 16'(g == 1));
        check_output("wr_en", mem_wr_en, 16'((g == 0 && r0_we) || (g == 1 && r1_we)));
        check_output("mem_addr", mem_addr, (g == 1) ? r1_addr : r0_addr);
        check_output("mem_dat_in", mem_dat_in, (g == 1) ? r1_wdata : r0_wdata);
        @(posedge clk);
        model_update(g);
        #1;
        check_output("rvalid0", r0_rvalid, m_rv[0]);
        check_output("rvalid1", r1_rvalid, m_rv[1]);
        check_output("rdata0", r0_rdata, m_rd[0]);
        check_output("rdata1", r1_rdata, m_rd[1]);
    endtask

    vec_t vecs [21];
    bit   pend0, pend1;
    int   cnt0;
    bit   r1_won;

    initial begin
        for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; shadow[i] = 8'h00; end
        m_owner = -1; m_prio = 0; m_run = 0; last_g = -1;
        m_rv = '{1'b0, 1'b0}; m_rd = '{8'h00, 8'h00};

        //               rst q0 l0 w0 a0     d0     q1 l1 w1 a1     d1     g0 g1 wr rv0 rv1 rd0    rd1
        vecs[0]  = mk_vec(1, 1, 0, 1, 8'h10, 8'hA5, 1, 0, 1, 8'h12, 8'h77, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        vecs[1]  = mk_vec(0, 1, 0, 1, 8'h10, 8'hA5, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0, 8'h00, 8'h00);
        vecs[2]  = mk_vec(0, 1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'hA5, 8'h00);
        vecs[3]  = mk_vec(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'hA5, 8'h00);
        vecs[4]  = mk_vec(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        vecs[5]  = mk_vec(0, 1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 1, 0, 8'hA5, 8'h00);
        vecs[6]  = mk_vec(0, 1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h10, 8'h00, 0, 1, 0, 0, 1, 8'hA5, 8'hA5);
        vecs[7]  = mk_vec(0, 1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 1, 0, 8'hA5, 8'hA5);
        vecs[8]  = mk_vec(0, 1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h10, 8'h00, 0, 1, 0, 0, 1, 8'hA5, 8'hA5);
        vecs[9]  = mk_vec(0, 1, 0, 1, 8'h30, 8'h11, 1, 1, 1, 8'h20, 8'hAA, 1, 0, 1, 0, 0, 8'hA5, 8'hA5);
        vecs[10] = mk_vec(0, 1, 0, 0, 8'h30, 8'h00, 1, 1, 1, 8'h20, 8'hAA, 0, 1, 1, 0, 0, 8'hA5, 8'hA5);
        vecs[11] = mk_vec(0, 1, 0, 0, 8'h30, 8'h00, 1, 1, 1, 8'h21, 8'hBB, 0, 1, 1, 0, 0, 8'hA5, 8'hA5);
        vecs[12] = mk_vec(0, 1, 0, 0, 8'h30, 8'h00, 1, 1, 1, 8'h22, 8'hCC, 0, 1, 1, 0, 0, 8'hA5, 8'hA5);
        vecs[13] = mk_vec(0, 1, 0, 0, 8'h30, 8'h00, 1, 0, 1, 8'h23, 8'hDD, 0, 1, 1, 0, 0, 8'hA5, 8'hA5);
        vecs[14] = mk_vec(0, 1, 0, 0, 8'h30, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'h11, 8'hA5);
        vecs[15] = mk_vec(0, 1, 1, 1, 8'h40, 8'h01, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0, 8'h11, 8'hA5);
        vecs[16] = mk_vec(0, 1, 1, 1, 8'h41, 8'h02, 1, 0, 0, 8'h20, 8'h00, 1, 0, 1, 0, 0, 8'h11, 8'hA5);
        vecs[17] = mk_vec(0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h20, 8'h00, 0, 1, 0, 0, 1, 8'h11, 8'hAA);
        vecs[18] = mk_vec(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h50, 8'hEE, 0, 1, 1, 0, 0, 8'h11, 8'hAA);
        vecs[19] = mk_vec(1, 1, 0, 0, 8'h30, 8'h00, 1, 1, 1, 8'h51, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        vecs[20] = mk_vec(0, 1, 0, 0, 8'h20, 8'h00, 1, 0, 0, 8'h21, 8'h00, 1, 0, 0, 1, 0, 8'hAA, 8'h00);

        @(negedge clk);
        for (int i = 0; i < 21; i++) begin
            apply_stimulus(vecs[i]);
            #1;
            check_output($sformatf("tbl%0d_gnt0", i), r0_gnt, vecs[i].eg0);
            check_output($sformatf("tbl%0d_gnt1", i), r1_gnt, vecs[i].eg1);
            check_output($sformatf("tbl%0d_wr_en", i), mem_wr_en, vecs[i].ewr);
            run_cycle();
            check_output($sformatf("tbl%0d_rvalid0", i), r0_rvalid, vecs[i].erv0);
            check_output($sformatf("tbl%0d_rvalid1", i), r1_rvalid, vecs[i].erv1);
            check_output($sformatf("tbl%0d_rdata0", i), r0_rdata, vecs[i].erd0);
            check_output($sformatf("tbl%0d_rdata1", i), r1_rdata, vecs[i].erd1);
            @(negedge clk);
        end
        check_output("mem_20", mem[8'h20], 8'hAA);
        check_output("mem_21", mem[8'h21], 8'hBB);
        check_output("mem_22", mem[8'h22], 8'hCC);
        check_output("mem_23", mem[8'h23], 8'hDD);
        check_output("mem_40", mem[8'h40], 8'h01);
        check_output("mem_41", mem[8'h41], 8'h02);
        check_output("mem_50", mem[8'h50], 8'hEE);
        check_output("mem_51_suppressed", mem[8'h51], 8'h00);

        // r0 holds lock permanently: exactly ML grants, then the waiting r1 gets the bus.
        apply_stimulus(mk_vec(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00));
        run_cycle();
        @(negedge clk);
        cnt0 = 0; r1_won = 1'b0;
        apply_stimulus(mk_vec(0, 1, 1, 0, 8'h05, 8'h00, 1, 0, 0, 8'h06, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00));
        for (int c = 0; c < 40 && !r1_won; c++) begin
            #1;
            if (r1_gnt) r1_won = 1'b1;
            else if (r0_gnt) cnt0++;
            run_cycle();
            @(negedge clk);
        end
        check_output("maxlock_r0_grants", 16'(cnt0), 16'(ML));
        check_output("maxlock_r1_granted", 16'(r1_won), 16'd1);

        // Randomized traffic; each requester holds its transaction until it is granted.
        pend0 = 1'b0; pend1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 49) == 0);
            if (!pend0) begin
                r0_req = ($urandom_range(0, 3) != 0); r0_lock = ($urandom_range(0, 2) == 0);
                r0_we = 1'($urandom_range(0, 1)); r0_addr = 8'($urandom_range(0, 15)); r0_wdata = 8'($urandom);
                pend0 = r0_req;
            end
            if (!pend1) begin
                r1_req = ($urandom_range(0, 3) != 0); r1_lock = ($urandom_range(0, 2) == 0);
                r1_we = 1'($urandom_range(0, 1)); r1_addr = 8'($urandom_range(0, 15)); r1_wdata = 8'($urandom);
                pend1 = r1_req;
            end
            run_cycle();
            if (last_g == 0 || reset) pend0 = 1'b0;
            if (last_g == 1 || reset) pend1 = 1'b0;
            @(negedge clk);
        end

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
